ctl_gpr_pipe: RTL

Parametrised, clocked successor to the single-stage four-phase request/acknowledge controller. It chains DEPTH C-element handshake stages with a WIDTH-bit data latch per stage, forming an elastic micropipeline between a four-phase producer and a four-phase consumer. It sits between GPR-side producers and consumers that exchange data with req/ack handshakes. It adds a global freeze, occupancy/busy reporting, and sticky protocol-violation flags.

---
 rtl/ctl_gpr_pipe_if.sv | 25 ++
 rtl/ctl_gpr_pipe.sv | 83 ++++++++
 2 files changed

// File: rtl/ctl_gpr_pipe_if.sv
// Handshake bundle between a four-phase producer, the elastic pipe and a four-phase consumer.
// The pipe takes the slave view. The environment driving req/data/ack_o takes the master view.
interface ctl_gpr_pipe_if #(
    parameter int WIDTH = 8
);
    logic             en_i;
    logic             req_i;
    logic [WIDTH-1:0] data_i;
    logic             ack_i;
    logic             req_o;
    logic [WIDTH-1:0] data_o;
    logic             ack_o;
    logic             busy_o;
    logic [1:0]       err_o;

    modport master (
        output en_i, req_i, data_i, ack_o,
        input  ack_i, req_o, data_o, busy_o, err_o
    );

    modport slave (
        input  en_i, req_i, data_i, ack_o,
        output ack_i, req_o, data_o, busy_o, err_o
    );
endinterface

// File: rtl/ctl_gpr_pipe.sv
// Clocked micropipeline: DEPTH C-element handshake stages, each with a WIDTH-bit data latch.
// It also provides a global freeze, busy reporting and sticky flags for four-phase protocol violations.
module ctl_gpr_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ctl_gpr_pipe_if.slave  bus
);

    logic [DEPTH-1:0] c_reg;
    logic [DEPTH-1:0] c_next;
    logic [DEPTH-1:0] a_vec;
    logic [DEPTH-1:0] b_vec;
    logic [WIDTH-1:0] d_reg [DEPTH];
    logic [WIDTH-1:0] d_src [DEPTH];
    logic             req_prev_reg;
    logic             ack_prev_reg;
    logic [1:0]       err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign a_vec[gi] = bus.req_i;
                assign d_src[gi] = bus.data_i;
            end else begin : g_link
                assign a_vec[gi] = c_reg[gi-1];
                assign d_src[gi] = d_reg[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_tail
                assign b_vec[gi] = bus.ack_o;
            end else begin : g_fwd
                assign b_vec[gi] = c_reg[gi+1];
            end

            // C-element of a and !b: set when both true, clear when both false, else hold.
            assign c_next[gi] = (a_vec[gi] & ~b_vec[gi]) |
                                (c_reg[gi] & (a_vec[gi] | ~b_vec[gi]));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_reg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_reg[k] <= '0;
            end
        end else if (bus.en_i) begin
            c_reg <= c_next;
            // A stage latches its data only on its own rising transition.
            for (int k = 0; k < DEPTH; k++) begin
                if (c_next[k] && !c_reg[k]) begin
                    d_reg[k] <= d_src[k];
                end
            end
        end
    end

    // Protocol monitors keep sampling while the pipe is frozen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_prev_reg <= 1'b0;
            ack_prev_reg <= 1'b0;
            err_reg      <= 2'b00;
        end else begin
            req_prev_reg <= bus.req_i;
            ack_prev_reg <= bus.ack_o;
            err_reg      <= err_reg |
                            {~ack_prev_reg & bus.ack_o & ~c_reg[DEPTH-1],
                             req_prev_reg & ~bus.req_i & ~c_reg[0]};
        end
    end

    assign bus.ack_i  = c_reg[0];
    assign bus.req_o  = c_reg[DEPTH-1];
    assign bus.data_o = d_reg[DEPTH-1];
    assign bus.busy_o = |c_reg;
    assign bus.err_o  = err_reg;

endmodule
